// File: rtl/axi_addr_remap.sv
// AXI4 address remapper: decodes AR/AW against base/mask windows, rewrites hits to a
// per-region target and answers unmapped accesses locally with DECERR.
module axi_addr_remap #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int ID_WIDTH    = 4,
    parameter int NUM_REGIONS = 2,
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE   = {NUM_REGIONS{32'h0}},
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK   = {NUM_REGIONS{32'h0FFFFFFF}},
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_TARGET = {NUM_REGIONS{32'h10000000}},
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    // upstream write address
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    // upstream read
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    // downstream write
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic [3:0]              m_axi_awqos,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    // downstream read
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic [3:0]              m_axi_arqos,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic {R_IDLE, R_ERR} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_FWD, W_ERR_DATA, W_ERR_RESP} w_state_e;

    // Returns {hit, remapped address}; scanning high to low lets the lowest index win.
    function automatic logic [ADDR_WIDTH:0] decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] base;
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] tgt;
        logic [ADDR_WIDTH:0]   res;
        res = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            base = REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
            mask = REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
            tgt  = REGION_TARGET[i*ADDR_WIDTH +: ADDR_WIDTH];
            if ((addr & ~mask) == (base & ~mask))
                res = {1'b1, (tgt & ~mask) | (addr & mask)};
        end
        return res;
    endfunction

    logic [ADDR_WIDTH:0] ar_dec;
    logic [ADDR_WIDTH:0] aw_dec;
    logic                ar_hit;
    logic                aw_hit;

    assign ar_dec = decode(s_axi_araddr);
    assign aw_dec = decode(s_axi_awaddr);
    assign ar_hit = ar_dec[ADDR_WIDTH];
    assign aw_hit = aw_dec[ADDR_WIDTH];

    assign m_axi_arid    = s_axi_arid;
    assign m_axi_araddr  = ar_dec[ADDR_WIDTH-1:0];
    assign m_axi_arlen   = s_axi_arlen;
    assign m_axi_arsize  = s_axi_arsize;
    assign m_axi_arburst = s_axi_arburst;
    assign m_axi_arlock  = s_axi_arlock;
    assign m_axi_arcache = s_axi_arcache;
    assign m_axi_arprot  = s_axi_arprot;
    assign m_axi_arqos   = s_axi_arqos;

    assign m_axi_awid    = s_axi_awid;
    assign m_axi_awaddr  = aw_dec[ADDR_WIDTH-1:0];
    assign m_axi_awlen   = s_axi_awlen;
    assign m_axi_awsize  = s_axi_awsize;
    assign m_axi_awburst = s_axi_awburst;
    assign m_axi_awlock  = s_axi_awlock;
    assign m_axi_awcache = s_axi_awcache;
    assign m_axi_awprot  = s_axi_awprot;
    assign m_axi_awqos   = s_axi_awqos;

    assign m_axi_wdata = s_axi_wdata;
    assign m_axi_wstrb = s_axi_wstrb;
    assign m_axi_wlast = s_axi_wlast;

    r_state_e            r_state_q, r_state_d;
    w_state_e            w_state_q, w_state_d;
    logic [CW-1:0]       rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]       wr_cnt_q, wr_cnt_d;
    logic [7:0]          r_beat_q, r_beat_d;
    logic [7:0]          r_len_q, r_len_d;
    logic [ID_WIDTH-1:0] r_id_q, r_id_d;
    logic [ID_WIDTH-1:0] w_id_q, w_id_d;

    logic rd_room, rd_empty, wr_room, wr_empty;
    logic rd_inc, rd_dec, wr_inc, wr_dec;

    assign rd_room  = rd_cnt_q < MAX_CNT;
    assign rd_empty = rd_cnt_q == '0;
    assign wr_room  = wr_cnt_q < MAX_CNT;
    assign wr_empty = wr_cnt_q == '0;

    assign rd_inc = m_axi_arvalid && m_axi_arready;
    assign rd_dec = m_axi_rvalid && m_axi_rready && m_axi_rlast;
    assign wr_inc = m_axi_awvalid && m_axi_awready;
    assign wr_dec = m_axi_bvalid && m_axi_bready;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (rd_inc && !rd_dec)      rd_cnt_d = rd_cnt_q + CW'(1);
        else if (!rd_inc && rd_dec) rd_cnt_d = rd_cnt_q - CW'(1);
        if (wr_inc && !wr_dec)      wr_cnt_d = wr_cnt_q + CW'(1);
        else if (!wr_inc && wr_dec) wr_cnt_d = wr_cnt_q - CW'(1);
    end

    // Read path: local DECERR bursts only start with nothing forwarded in flight,
    // so they can never interleave with downstream R beats.
    always_comb begin
        r_state_d     = r_state_q;
        r_beat_d      = r_beat_q;
        r_len_d       = r_len_q;
        r_id_d        = r_id_q;
        m_axi_arvalid = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = m_axi_rvalid;
        s_axi_rid     = m_axi_rid;
        s_axi_rdata   = m_axi_rdata;
        s_axi_rresp   = m_axi_rresp;
        s_axi_rlast   = m_axi_rlast;
        m_axi_rready  = s_axi_rready;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hit) begin
                    m_axi_arvalid = s_axi_arvalid && rd_room;
                    s_axi_arready = m_axi_arready && rd_room;
                end else begin
                    s_axi_arready = rd_empty;
                    if (s_axi_arvalid && rd_empty) begin
                        r_id_d    = s_axi_arid;
                        r_len_d   = s_axi_arlen;
                        r_beat_d  = '0;
                        r_state_d = R_ERR;
                    end
                end
            end
            R_ERR: begin
                s_axi_rvalid = 1'b1;
                s_axi_rid    = r_id_q;
                s_axi_rdata  = '0;
                s_axi_rresp  = 2'b11;
                s_axi_rlast  = (r_beat_q == r_len_q);
                m_axi_rready = 1'b0;
                if (s_axi_rready) begin
                    if (r_beat_q == r_len_q) r_state_d = R_IDLE;
                    else                     r_beat_d  = r_beat_q + 8'd1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Write path: one AW at a time owns the W channel until its last beat.
    always_comb begin
        w_state_d     = w_state_q;
        w_id_d        = w_id_q;
        m_axi_awvalid = 1'b0;
        s_axi_awready = 1'b0;
        m_axi_wvalid  = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = m_axi_bvalid;
        s_axi_bid     = m_axi_bid;
        s_axi_bresp   = m_axi_bresp;
        m_axi_bready  = s_axi_bready;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hit) begin
                    m_axi_awvalid = s_axi_awvalid && wr_room;
                    s_axi_awready = m_axi_awready && wr_room;
                    if (s_axi_awvalid && m_axi_awready && wr_room) w_state_d = W_FWD;
                end else begin
                    s_axi_awready = wr_empty;
                    if (s_axi_awvalid && wr_empty) begin
                        w_id_d    = s_axi_awid;
                        w_state_d = W_ERR_DATA;
                    end
                end
            end
            W_FWD: begin
                m_axi_wvalid = s_axi_wvalid;
                s_axi_wready = m_axi_wready;
                if (s_axi_wvalid && m_axi_wready && s_axi_wlast) w_state_d = W_IDLE;
            end
            W_ERR_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && s_axi_wlast) w_state_d = W_ERR_RESP;
            end
            W_ERR_RESP: begin
                s_axi_bvalid = 1'b1;
                s_axi_bid    = w_id_q;
                s_axi_bresp  = 2'b11;
                m_axi_bready = 1'b0;
                if (s_axi_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            w_state_q <= W_IDLE;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            r_beat_q  <= '0;
            r_len_q   <= '0;
            r_id_q    <= '0;
            w_id_q    <= '0;
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            r_beat_q  <= r_beat_d;
            r_len_q   <= r_len_d;
            r_id_q    <= r_id_d;
            w_id_q    <= w_id_d;
        end
    end

endmodule

// File: tb/tb_axi_addr_remap.sv
// Directed bench for axi_addr_remap: three overlapping-capable regions, two outstanding per direction.
module tb_axi_addr_remap;

    logic        aclk;
    logic        aresetn;
    logic [3:0]  s_axi_awid;
    logic [31:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_awlock;
    logic [3:0]  s_axi_awcache;
    logic [2:0]  s_axi_awprot;
    logic [3:0]  s_axi_awqos;
    logic        s_axi_awvalid, s_axi_awready;
    logic [63:0] s_axi_wdata;
    logic [7:0]  s_axi_wstrb;
    logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid, s_axi_bready;
    logic [3:0]  s_axi_arid;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arlock;
    logic [3:0]  s_axi_arcache;
    logic [2:0]  s_axi_arprot;
    logic [3:0]  s_axi_arqos;
    logic        s_axi_arvalid, s_axi_arready;
    logic [3:0]  s_axi_rid;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic [3:0]  m_axi_awid;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awlock;
    logic [3:0]  m_axi_awcache;
    logic [2:0]  m_axi_awprot;
    logic [3:0]  m_axi_awqos;
    logic        m_axi_awvalid, m_axi_awready;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_bid;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic [3:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic [3:0]  m_axi_arqos;
    logic        m_axi_arvalid, m_axi_arready;
    logic [3:0]  m_axi_rid;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    int checks = 0;
    int errors = 0;

    // Region 0: 0x0xxx_xxxx -> 0x1xxx_xxxx; region 1: 0x8000_xxxx -> 0x4000_xxxx;
    // region 2: 0x8xxx_xxxx -> 0x2xxx_xxxx (overlaps region 1, loses to it).
    axi_addr_remap #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4), .NUM_REGIONS(3),
        .REGION_BASE  ({32'h8000_0000, 32'h8000_0000, 32'h0000_0000}),
        .REGION_MASK  ({32'h0FFF_FFFF, 32'h0000_FFFF, 32'h0FFF_FFFF}),
        .REGION_TARGET({32'h2000_0000, 32'h4000_0000, 32'h1000_0000}),
        .MAX_OUTSTANDING(2)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic idle_inputs();
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
        s_axi_awburst = '0; s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0;
        s_axi_awqos = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = '0; s_axi_arlock = 1'b0; s_axi_arcache = '0; s_axi_arprot = '0;
        s_axi_arqos = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        idle_inputs();
        repeat (2) @(negedge aclk);
        #1;
        checks++;
        if ({s_axi_rvalid, s_axi_bvalid, s_axi_wready, m_axi_arvalid, m_axi_awvalid} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_idle: got rvalid,bvalid,wready,arvalid,awvalid=%b expected 00000",
                     {s_axi_rvalid, s_axi_bvalid, s_axi_wready, m_axi_arvalid, m_axi_awvalid});
        end
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0000_0100;
        #1;
        checks++;
        if (m_axi_arvalid !== 1'b1) begin
            errors++;
            $display("FAIL reset_ar_follow: got m_axi_arvalid=%b expected 1", m_axi_arvalid);
        end
        s_axi_arvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic test_read_mapped();
        logic [63:0] exp_data;
        @(negedge aclk);
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0123_4560; s_axi_arid = 4'd3; s_axi_arlen = 8'd3;
        s_axi_arsize = 3'd3; s_axi_arburst = 2'd1; s_axi_arcache = 4'h3; s_axi_arprot = 3'd2;
        s_axi_arqos = 4'h5; s_axi_arlock = 1'b1; m_axi_arready = 1'b0;
        #1;
        checks++;
        if ({m_axi_arvalid, s_axi_arready, m_axi_araddr} !== {1'b1, 1'b0, 32'h1123_4560}) begin
            errors++;
            $display("FAIL rd_map_addr: got valid,ready,addr=%b,%b,%h expected 1,0,11234560",
                     m_axi_arvalid, s_axi_arready, m_axi_araddr);
        end
        checks++;
        if ({m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache,
             m_axi_arprot, m_axi_arqos} !== {4'd3, 8'd3, 3'd3, 2'd1, 1'b1, 4'h3, 3'd2, 4'h5}) begin
            errors++;
            $display("FAIL rd_fields: got id=%h len=%h size=%h burst=%h expected 3,03,3,1",
                     m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst);
        end
        @(negedge aclk);
        m_axi_arready = 1'b1;
        #1;
        checks++;
        if (s_axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL rd_map_ready: got s_axi_arready=%b expected 1", s_axi_arready);
        end
        @(negedge aclk);
        s_axi_arvalid = 1'b0; s_axi_arlock = 1'b0; m_axi_arready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_data = 64'hDEAD_BEEF_0000_0000 + 64'(i);
            m_axi_rvalid = 1'b1; m_axi_rid = 4'd3; m_axi_rdata = exp_data; m_axi_rresp = 2'b00;
            m_axi_rlast = (i == 3); s_axi_rready = 1'b1;
            #1;
            checks++;
            if ({s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, m_axi_rready} !==
                {1'b1, 4'd3, exp_data, 2'b00, (i == 3), 1'b1}) begin
                errors++;
                $display("FAIL rd_beat%0d: got v=%b id=%h data=%h last=%b expected 1,3,%h,%b",
                         i, s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rlast, exp_data, (i == 3));
            end
            @(negedge aclk);
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; s_axi_rready = 1'b0;
    endtask

    // Combinational decode only; arvalid drops before the edge so nothing is accepted.
    task automatic test_decode();
        logic [31:0] addr_v [7];
        logic [31:0] exp_v  [7];
        logic        hit_v  [7];
        addr_v = '{32'h0FFF_FFFF, 32'h0000_0000, 32'h1000_0000, 32'h8000_1234,
                   32'h8001_0000, 32'h8FFF_FFFF, 32'h9000_0000};
        exp_v  = '{32'h1FFF_FFFF, 32'h1000_0000, 32'h0, 32'h4000_1234,
                   32'h2001_0000, 32'h2FFF_FFFF, 32'h0};
        hit_v  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        m_axi_arready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge aclk);
            s_axi_arvalid = 1'b1; s_axi_araddr = addr_v[i];
            #1;
            checks++;
            if ({m_axi_arvalid, s_axi_arready} !== {hit_v[i], ~hit_v[i]}) begin
                errors++;
                $display("FAIL decode_hit %h: got arvalid,arready=%b%b expected %b%b",
                         addr_v[i], m_axi_arvalid, s_axi_arready, hit_v[i], ~hit_v[i]);
            end
            if (hit_v[i]) begin
                checks++;
                if (m_axi_araddr !== exp_v[i]) begin
                    errors++;
                    $display("FAIL decode_addr %h: got %h expected %h", addr_v[i], m_axi_araddr, exp_v[i]);
                end
            end
            s_axi_arvalid = 1'b0;
        end
    endtask

    task automatic test_write_remap();
        logic [63:0] exp_data;
        @(negedge aclk);
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h8000_1234; s_axi_awid = 4'd2; s_axi_awlen = 8'd1;
        s_axi_awsize = 3'd3; s_axi_awburst = 2'd1; m_axi_awready = 1'b1;
        s_axi_wvalid = 1'b1; s_axi_wdata = 64'h0; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b0;
        m_axi_wready = 1'b1;
        #1;
        checks++;
        if ({m_axi_awvalid, s_axi_awready, m_axi_awaddr, m_axi_awid, m_axi_awlen} !==
            {1'b1, 1'b1, 32'h4000_1234, 4'd2, 8'd1}) begin
            errors++;
            $display("FAIL wr_remap: got v=%b r=%b addr=%h id=%h expected 1,1,40001234,2",
                     m_axi_awvalid, s_axi_awready, m_axi_awaddr, m_axi_awid);
        end
        checks++;
        if ({m_axi_wvalid, s_axi_wready} !== 2'b00) begin
            errors++;
            $display("FAIL wr_w_before_aw: got wvalid,wready=%b%b expected 00", m_axi_wvalid, s_axi_wready);
        end
        @(negedge aclk);
        s_axi_awvalid = 1'b0; m_axi_awready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_data = 64'h1111_2222_3333_0000 + 64'(i);
            s_axi_wdata = exp_data; s_axi_wlast = (i == 1);
            #1;
            checks++;
            if ({m_axi_wvalid, s_axi_wready, m_axi_wdata, m_axi_wstrb, m_axi_wlast} !==
                {1'b1, 1'b1, exp_data, 8'hFF, (i == 1)}) begin
                errors++;
                $display("FAIL wr_beat%0d: got v=%b r=%b data=%h last=%b expected 1,1,%h,%b",
                         i, m_axi_wvalid, s_axi_wready, m_axi_wdata, m_axi_wlast, exp_data, (i == 1));
            end
            @(negedge aclk);
        end
        #1;
        checks++;
        if ({m_axi_wvalid, s_axi_wready} !== 2'b00) begin
            errors++;
            $display("FAIL wr_w_after_last: got wvalid,wready=%b%b expected 00", m_axi_wvalid, s_axi_wready);
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b1; m_axi_bid = 4'd2; m_axi_bresp = 2'b01; s_axi_bready = 1'b1;
        #1;
        checks++;
        if ({s_axi_bvalid, s_axi_bid, s_axi_bresp, m_axi_bready} !== {1'b1, 4'd2, 2'b01, 1'b1}) begin
            errors++;
            $display("FAIL wr_b_pass: got v=%b id=%h resp=%b bready=%b expected 1,2,01,1",
                     s_axi_bvalid, s_axi_bid, s_axi_bresp, m_axi_bready);
        end
        @(negedge aclk);
        m_axi_bvalid = 1'b0; s_axi_bready = 1'b0;
    endtask

    task automatic test_read_unmapped();
        int beat;
        int cyc;
        @(negedge aclk);
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'hF000_0000; s_axi_arid = 4'd5; s_axi_arlen = 8'd2;
        m_axi_arready = 1'b1;
        #1;
        checks++;
        if ({m_axi_arvalid, s_axi_arready} !== 2'b01) begin
            errors++;
            $display("FAIL rd_err_accept: got arvalid,arready=%b%b expected 01", m_axi_arvalid, s_axi_arready);
        end
        @(negedge aclk);
        s_axi_arvalid = 1'b0; m_axi_arready = 1'b0;
        beat = 0;
        cyc = 0;
        while (beat < 3 && cyc < 20) begin
            s_axi_rready = cyc[0];
            #1;
            checks++;
            if ({s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, m_axi_rready, s_axi_arready} !==
                {1'b1, 4'd5, 64'h0, 2'b11, (beat == 2), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL rd_err_beat%0d: got v=%b id=%h data=%h resp=%b last=%b mrdy=%b expected 1,5,0,11,%b,0",
                         beat, s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, m_axi_rready, (beat == 2));
            end
            if (s_axi_rready) beat++;
            cyc++;
            @(negedge aclk);
        end
        checks++;
        if (beat != 3) begin
            errors++;
            $display("FAIL rd_err_timeout: got %0d beats expected 3", beat);
        end
        s_axi_rready = 1'b0;
        #1;
        checks++;
        if (s_axi_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_err_done: got rvalid=%b expected 0", s_axi_rvalid);
        end
    endtask

    task automatic test_write_unmapped();
        @(negedge aclk);
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'hF000_0000; s_axi_awid = 4'd9; s_axi_awlen = 8'd3;
        m_axi_awready = 1'b1;
        #1;
        checks++;
        if ({m_axi_awvalid, s_axi_awready} !== 2'b01) begin
            errors++;
            $display("FAIL wr_err_accept: got awvalid,awready=%b%b expected 01", m_axi_awvalid, s_axi_awready);
        end
        @(negedge aclk);
        s_axi_awvalid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_axi_wvalid = 1'b1; s_axi_wdata = 64'hCAFE_0000_0000_0000 + 64'(i); s_axi_wlast = (i == 3);
            #1;
            checks++;
            if ({s_axi_wready, m_axi_wvalid, s_axi_bvalid} !== 3'b100) begin
                errors++;
                $display("FAIL wr_err_beat%0d: got wready,m_wvalid,bvalid=%b expected 100",
                         i, {s_axi_wready, m_axi_wvalid, s_axi_bvalid});
            end
            @(negedge aclk);
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; m_axi_wready = 1'b0; s_axi_bready = 1'b0;
        #1;
        checks++;
        if ({s_axi_bvalid, s_axi_bid, s_axi_bresp, m_axi_bready, s_axi_wready} !== {1'b1, 4'd9, 2'b11, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL wr_err_b: got v=%b id=%h resp=%b mbrdy=%b wready=%b expected 1,9,11,0,0",
                     s_axi_bvalid, s_axi_bid, s_axi_bresp, m_axi_bready, s_axi_wready);
        end
        @(negedge aclk);
        s_axi_bready = 1'b1;
        @(negedge aclk);
        s_axi_bready = 1'b0;
        #1;
        checks++;
        if (s_axi_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_err_b_done: got bvalid=%b expected 0", s_axi_bvalid);
        end
    endtask

    task automatic test_outstanding();
        @(negedge aclk);
        m_axi_arready = 1'b1; s_axi_arvalid = 1'b1; s_axi_arlen = 8'd0;
        s_axi_araddr = 32'h0000_0100; s_axi_arid = 4'd1;
        #1;
        checks++;
        if (s_axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL os_ar1: got arready=%b expected 1", s_axi_arready);
        end
        @(negedge aclk);
        s_axi_araddr = 32'h0000_0200; s_axi_arid = 4'd2;
        #1;
        checks++;
        if (s_axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL os_ar2: got arready=%b expected 1", s_axi_arready);
        end
        @(negedge aclk);
        s_axi_araddr = 32'h0000_0300; s_axi_arid = 4'd3;
        #1;
        checks++;
        if ({m_axi_arvalid, s_axi_arready} !== 2'b00) begin
            errors++;
            $display("FAIL os_ar3_full: got arvalid,arready=%b%b expected 00", m_axi_arvalid, s_axi_arready);
        end
        @(negedge aclk);
        m_axi_rvalid = 1'b1; m_axi_rid = 4'd1; m_axi_rlast = 1'b1; s_axi_rready = 1'b1;
        #1;
        checks++;
        if ({s_axi_arready, m_axi_rready} !== 2'b01) begin
            errors++;
            $display("FAIL os_ar3_same_cycle: got arready,rready=%b%b expected 01", s_axi_arready, m_axi_rready);
        end
        @(negedge aclk);
        m_axi_rvalid = 1'b0;
        #1;
        checks++;
        if ({m_axi_arvalid, s_axi_arready} !== 2'b11) begin
            errors++;
            $display("FAIL os_ar3_freed: got arvalid,arready=%b%b expected 11", m_axi_arvalid, s_axi_arready);
        end
        @(negedge aclk);
        s_axi_araddr = 32'hF000_0000; s_axi_arid = 4'd6;
        #1;
        checks++;
        if (s_axi_arready !== 1'b0) begin
            errors++;
            $display("FAIL os_unmapped_2: got arready=%b expected 0", s_axi_arready);
        end
        m_axi_rvalid = 1'b1; m_axi_rid = 4'd2;
        @(negedge aclk);
        m_axi_rid = 4'd3;
        #1;
        checks++;
        if (s_axi_arready !== 1'b0) begin
            errors++;
            $display("FAIL os_unmapped_1: got arready=%b expected 0", s_axi_arready);
        end
        @(negedge aclk);
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        #1;
        checks++;
        if (s_axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL os_unmapped_0: got arready=%b expected 1", s_axi_arready);
        end
        @(negedge aclk);
        s_axi_arvalid = 1'b0; m_axi_arready = 1'b0;
        #1;
        checks++;
        if ({s_axi_rvalid, s_axi_rid, s_axi_rlast, s_axi_rresp} !== {1'b1, 4'd6, 1'b1, 2'b11}) begin
            errors++;
            $display("FAIL os_err_beat: got v=%b id=%h last=%b resp=%b expected 1,6,1,11",
                     s_axi_rvalid, s_axi_rid, s_axi_rlast, s_axi_rresp);
        end
        @(negedge aclk);
        s_axi_rready = 1'b0;
        #1;
        checks++;
        if (s_axi_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL os_err_done: got rvalid=%b expected 0", s_axi_rvalid);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge aclk);
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'hF000_0000; s_axi_arid = 4'd4; s_axi_arlen = 8'd3;
        @(negedge aclk);
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        @(negedge aclk);
        s_axi_rready = 1'b0;
        #1;
        checks++;
        if (s_axi_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_rerr: got rvalid=%b expected 1", s_axi_rvalid);
        end
        #1 aresetn = 1'b0;
        #1;
        checks++;
        if (s_axi_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_rerr: got rvalid=%b expected 0", s_axi_rvalid);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0000_1000; s_axi_awid = 4'd1; s_axi_awlen = 8'd3;
        m_axi_awready = 1'b1;
        @(negedge aclk);
        s_axi_awvalid = 1'b0; m_axi_awready = 1'b0;
        s_axi_wvalid = 1'b1; s_axi_wlast = 1'b0; m_axi_wready = 1'b1;
        #1;
        checks++;
        if ({m_axi_wvalid, s_axi_wready} !== 2'b11) begin
            errors++;
            $display("FAIL rst_pre_wfwd: got wvalid,wready=%b%b expected 11", m_axi_wvalid, s_axi_wready);
        end
        @(negedge aclk);
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if ({m_axi_wvalid, s_axi_wready, s_axi_bvalid, s_axi_rvalid} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_wfwd: got wvalid,wready,bvalid,rvalid=%b expected 0000",
                     {m_axi_wvalid, s_axi_wready, s_axi_bvalid, s_axi_rvalid});
        end
        s_axi_wvalid = 1'b0; m_axi_wready = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0000_0040; s_axi_arid = 4'd7; s_axi_arlen = 8'd0;
        m_axi_arready = 1'b1;
        #1;
        checks++;
        if ({m_axi_arvalid, s_axi_arready, m_axi_araddr} !== {1'b1, 1'b1, 32'h1000_0040}) begin
            errors++;
            $display("FAIL rst_fresh_ar: got v=%b r=%b addr=%h expected 1,1,10000040",
                     m_axi_arvalid, s_axi_arready, m_axi_araddr);
        end
        @(negedge aclk);
        s_axi_arvalid = 1'b0; m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b1; m_axi_rid = 4'd7; m_axi_rdata = 64'h55; m_axi_rresp = 2'b00;
        m_axi_rlast = 1'b1; s_axi_rready = 1'b1;
        #1;
        checks++;
        if ({s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} !== {1'b1, 4'd7, 64'h55, 2'b00, 1'b1}) begin
            errors++;
            $display("FAIL rst_fresh_r: got v=%b id=%h data=%h last=%b expected 1,7,55,1",
                     s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rlast);
        end
        @(negedge aclk);
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; s_axi_rready = 1'b0;
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'hF000_0000;
        #1;
        checks++;
        if (s_axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL rst_fresh_cnt: got unmapped arready=%b expected 1", s_axi_arready);
        end
        s_axi_arvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_mapped();
        test_decode();
        test_write_remap();
        test_read_unmapped();
        test_write_unmapped();
        test_outstanding();
        test_reset_mid();
        repeat (2) @(negedge aclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
